// File: rtl/zvc_decompressor.sv
// zvc_decompressor: scatters a zero-value-compressed line back to its original lanes
// using the nonzero mask; two-stage valid/ready pipeline (prefix sum, then expansion).
module zvc_decompressor #(
   parameter int WORD_WIDTH    = 8,
   parameter int LINE_SIZE     = 128,
   parameter int DIST_WIDTH    = 7,
   parameter int MAX_LIFM_RSIZ = 4,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                                          clk,
   input  logic                                          reset_n,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [LINE_SIZE*WORD_WIDTH-1:0]               lifm_comp,
   input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_comp,
   input  logic [LINE_SIZE-1:0]                          mask,
   input  logic [CNT_WIDTH-1:0]                          in_cnt,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [LINE_SIZE*WORD_WIDTH-1:0]               lifm_line,
   output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_line,
   output logic [CNT_WIDTH-1:0]                          out_cnt,
   output logic                                          cnt_err
);
   localparam int LW = LINE_SIZE*WORD_WIDTH;
   localparam int ME = DIST_WIDTH*MAX_LIFM_RSIZ;
   localparam int MW = LINE_SIZE*ME;

   logic                                s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic [LW-1:0]                       s1_lifm_q, s1_lifm_d, lifm_line_q, lifm_line_d;
   logic [MW-1:0]                       s1_mt_q, s1_mt_d, mt_line_q, mt_line_d;
   logic [LINE_SIZE-1:0]                s1_mask_q, s1_mask_d;
   logic [LINE_SIZE-1:0][CNT_WIDTH-1:0] psum_q, psum_d, psum_c;
   logic [CNT_WIDTH-1:0]                s1_total_q, s1_total_d, out_cnt_q, out_cnt_d, acc;
   logic                                s1_err_q, s1_err_d, cnt_err_q, cnt_err_d;
   logic                                s1_adv, s2_adv;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q  <= 1'b0;
         s2_valid_q  <= 1'b0;
         s1_lifm_q   <= '0;
         s1_mt_q     <= '0;
         s1_mask_q   <= '0;
         psum_q      <= '0;
         s1_total_q  <= '0;
         s1_err_q    <= 1'b0;
         lifm_line_q <= '0;
         mt_line_q   <= '0;
         out_cnt_q   <= '0;
         cnt_err_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s2_valid_q  <= s2_valid_d;
         s1_lifm_q   <= s1_lifm_d;
         s1_mt_q     <= s1_mt_d;
         s1_mask_q   <= s1_mask_d;
         psum_q      <= psum_d;
         s1_total_q  <= s1_total_d;
         s1_err_q    <= s1_err_d;
         lifm_line_q <= lifm_line_d;
         mt_line_q   <= mt_line_d;
         out_cnt_q   <= out_cnt_d;
         cnt_err_q   <= cnt_err_d;
      end
   end

   always_comb begin
      s2_adv     = !s2_valid_q | out_ready;
      s1_adv     = !s1_valid_q | s2_adv;
      s1_valid_d = s1_adv ? in_valid : s1_valid_q;
      s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
      acc        = '0;
      psum_c     = '0;
      for (int i = 0; i < LINE_SIZE; i++) begin
         psum_c[i] = acc;
         acc       = acc + CNT_WIDTH'(mask[i]);
      end
      s1_lifm_d  = s1_lifm_q;
      s1_mt_d    = s1_mt_q;
      s1_mask_d  = s1_mask_q;
      psum_d     = psum_q;
      s1_total_d = s1_total_q;
      s1_err_d   = s1_err_q;
      if (in_valid && s1_adv) begin
         s1_lifm_d  = lifm_comp;
         s1_mt_d    = mt_comp;
         s1_mask_d  = mask;
         psum_d     = psum_c;
         s1_total_d = acc;
         s1_err_d   = in_cnt != acc;
      end
      lifm_line_d = lifm_line_q;
      mt_line_d   = mt_line_q;
      out_cnt_d   = out_cnt_q;
      cnt_err_d   = cnt_err_q;
      // psum[i] <= i, so the gather index never leaves the line
      if (s2_adv && s1_valid_q) begin
         for (int i = 0; i < LINE_SIZE; i++) begin
            lifm_line_d[i*WORD_WIDTH +: WORD_WIDTH] = s1_mask_q[i] ? s1_lifm_q[psum_q[i]*WORD_WIDTH +: WORD_WIDTH] : '0;
            mt_line_d[i*ME +: ME] = s1_mask_q[i] ? s1_mt_q[psum_q[i]*ME +: ME] : '0;
         end
         out_cnt_d = s1_total_q;
         cnt_err_d = s1_err_q;
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = s2_valid_q;
   assign lifm_line = lifm_line_q;
   assign mt_line   = mt_line_q;
   assign out_cnt   = out_cnt_q;
   assign cnt_err   = cnt_err_q;
endmodule

// File: tb/tb_zvc_decompressor.sv
// tb_zvc_decompressor: directed vectors with hand-derived expected lines for zvc_decompressor.
module tb_zvc_decompressor;
   localparam int W  = 8;
   localparam int L  = 128;
   localparam int ME = 28;
   localparam int LW = L*W;
   localparam int MW = L*ME;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid, in_ready, out_valid, out_ready, cnt_err;
   logic [LW-1:0] lifm_comp, lifm_line;
   logic [MW-1:0] mt_comp, mt_line;
   logic [L-1:0]  mask;
   logic [7:0]    in_cnt, out_cnt;
   int            vectors = 0;
   int            miscompares = 0;

   always #5 clk = ~clk;

   zvc_decompressor dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .lifm_comp(lifm_comp), .mt_comp(mt_comp), .mask(mask), .in_cnt(in_cnt),
      .out_valid(out_valid), .out_ready(out_ready), .lifm_line(lifm_line),
      .mt_line(mt_line), .out_cnt(out_cnt), .cnt_err(cnt_err)
   );

   task automatic test_reset();
      reset_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      lifm_comp = '0; mt_comp = '0; mask = '0; in_cnt = '0;
      #1 reset_n = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      vectors++; if (lifm_line !== '0 || mt_line !== '0) begin miscompares++; $display("FAIL rst_lines lifm_bits=%0d mt_bits=%0d exp=0", $countones(lifm_line), $countones(mt_line)); end
      vectors++; if (out_cnt !== 8'd0 || cnt_err !== 1'b0) begin miscompares++; $display("FAIL rst_cnt got=%0d/%b exp=0/0", out_cnt, cnt_err); end
      @(negedge clk) reset_n = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_all_ones();
      logic [LW-1:0] el;
      for (int k = 0; k < L; k++) begin
         lifm_comp[k*W +: W] = 8'(k);
         el[k*W +: W]        = 8'(k);
         mt_comp[k*ME +: ME] = ME'(k*977 + 5);
      end
      mask = '1; in_cnt = 8'd128; in_valid = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ones_in_ready got=%b exp=1", in_ready); end
      @(negedge clk) in_valid = 1'b0;
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ones_valid got=%b exp=1", out_valid); end
      vectors++; if (lifm_line !== el) begin miscompares++; $display("FAIL ones_lifm got=%h exp=%h diffbits=%0d", lifm_line[63:0], el[63:0], $countones(lifm_line ^ el)); end
      vectors++; if (mt_line !== mt_comp) begin miscompares++; $display("FAIL ones_mt got=%h exp=%h diffbits=%0d", mt_line[63:0], mt_comp[63:0], $countones(mt_line ^ mt_comp)); end
      vectors++; if (out_cnt !== 8'd128 || cnt_err !== 1'b0) begin miscompares++; $display("FAIL ones_cnt got=%0d/%b exp=128/0", out_cnt, cnt_err); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ones_single got=%b exp=0", out_valid); end
   endtask

   task automatic test_zero_mask();
      lifm_comp = {L{8'hFF}}; mt_comp = '1; mask = '0; in_cnt = 8'd0; in_valid = 1'b1;
      @(negedge clk) in_valid = 1'b0;
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL zero_valid got=%b exp=1", out_valid); end
      vectors++; if (lifm_line !== '0 || mt_line !== '0) begin miscompares++; $display("FAIL zero_lines lifm_bits=%0d mt_bits=%0d exp=0", $countones(lifm_line), $countones(mt_line)); end
      vectors++; if (out_cnt !== 8'd0 || cnt_err !== 1'b0) begin miscompares++; $display("FAIL zero_cnt got=%0d/%b exp=0/0", out_cnt, cnt_err); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_single got=%b exp=0", out_valid); end
   endtask

   task automatic test_sparse();
      logic [LW-1:0] el;
      logic [MW-1:0] em;
      el = '0; em = '0;
      for (int k = 0; k < L; k++) begin
         lifm_comp[k*W +: W] = 8'(k + 1);
         mt_comp[k*ME +: ME] = ME'(k + 100);
      end
      for (int j = 0; j < L/2; j++) begin
         el[2*j*W +: W]   = 8'(j + 1);
         em[2*j*ME +: ME] = ME'(j + 100);
      end
      mask = {(L/2){2'b01}}; in_cnt = 8'd64; in_valid = 1'b1;
      @(negedge clk) in_valid = 1'b0;
      @(negedge clk);
      vectors++; if (lifm_line !== el) begin miscompares++; $display("FAIL alt_lifm got=%h exp=%h diffbits=%0d", lifm_line[63:0], el[63:0], $countones(lifm_line ^ el)); end
      vectors++; if (mt_line !== em) begin miscompares++; $display("FAIL alt_mt got=%h exp=%h diffbits=%0d", mt_line[63:0], em[63:0], $countones(mt_line ^ em)); end
      vectors++; if (out_cnt !== 8'd64 || cnt_err !== 1'b0) begin miscompares++; $display("FAIL alt_cnt got=%0d/%b exp=64/0", out_cnt, cnt_err); end
      el = '0; em = '0;
      el[(L-1)*W +: W]   = 8'hAB;
      em[(L-1)*ME +: ME] = 28'hABCDEF1;
      lifm_comp = {L{8'h11}}; lifm_comp[W-1:0] = 8'hAB;
      mt_comp = '1; mt_comp[ME-1:0] = 28'hABCDEF1;
      mask = '0; mask[L-1] = 1'b1; in_cnt = 8'd1; in_valid = 1'b1;
      @(negedge clk) in_valid = 1'b0;
      @(negedge clk);
      vectors++; if (lifm_line !== el) begin miscompares++; $display("FAIL top_lifm got=%h exp=%h diffbits=%0d", lifm_line[LW-1 -: 64], el[LW-1 -: 64], $countones(lifm_line ^ el)); end
      vectors++; if (mt_line !== em) begin miscompares++; $display("FAIL top_mt got=%h exp=%h diffbits=%0d", mt_line[MW-1 -: 64], em[MW-1 -: 64], $countones(mt_line ^ em)); end
      vectors++; if (out_cnt !== 8'd1) begin miscompares++; $display("FAIL top_cnt got=%0d exp=1", out_cnt); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      mt_comp = '0; mask = '0; mask[0] = 1'b1; in_cnt = 8'd1; out_ready = 1'b1;
      lifm_comp = {L{8'h5A}}; lifm_comp[W-1:0] = 8'hA1; mt_comp[ME-1:0] = 28'h00000A1; in_valid = 1'b1;
      @(negedge clk) lifm_comp[W-1:0] = 8'hB2; mt_comp[ME-1:0] = 28'h00000B2;
      @(negedge clk) lifm_comp[W-1:0] = 8'hC3; mt_comp[ME-1:0] = 28'h00000C3; out_ready = 1'b0;
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full got=%b exp=0", in_ready); end
      repeat (4) begin
         @(negedge clk);
         vectors++; if (out_valid !== 1'b1 || lifm_line !== LW'(8'hA1) || mt_line !== MW'(28'hA1)) begin miscompares++; $display("FAIL bp_hold_A got=%b/%h exp=1/a1", out_valid, lifm_line[7:0]); end
         vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hold_ready got=%b exp=0", in_ready); end
      end
      out_ready = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
      @(negedge clk) in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b1 || lifm_line !== LW'(8'hB2) || mt_line !== MW'(28'hB2)) begin miscompares++; $display("FAIL bp_B got=%b/%h exp=1/b2", out_valid, lifm_line[7:0]); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1 || lifm_line !== LW'(8'hC3) || mt_line !== MW'(28'hC3)) begin miscompares++; $display("FAIL bp_C got=%b/%h exp=1/c3", out_valid, lifm_line[7:0]); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_cnt_err();
      logic [LW-1:0] el;
      el = '0;
      for (int k = 0; k < L; k++) lifm_comp[k*W +: W] = 8'(k + 1);
      for (int k = 0; k < 10; k++) el[k*W +: W] = 8'(k + 1);
      mt_comp = '0; mask = 128'h3FF; in_cnt = 8'd9; in_valid = 1'b1;
      @(negedge clk) mask = 128'h3; in_cnt = 8'd2;
      @(negedge clk) in_valid = 1'b0;
      vectors++; if (cnt_err !== 1'b1 || out_cnt !== 8'd10) begin miscompares++; $display("FAIL err_flag got=%b/%0d exp=1/10", cnt_err, out_cnt); end
      vectors++; if (lifm_line !== el) begin miscompares++; $display("FAIL err_lifm got=%h exp=%h diffbits=%0d", lifm_line[79:0], el[79:0], $countones(lifm_line ^ el)); end
      @(negedge clk);
      vectors++; if (cnt_err !== 1'b0 || out_cnt !== 8'd2 || lifm_line !== LW'(16'h0201)) begin miscompares++; $display("FAIL err_next got=%b/%0d/%h exp=0/2/0201", cnt_err, out_cnt, lifm_line[15:0]); end
      @(negedge clk);
   endtask

   task automatic test_reset_midflight();
      lifm_comp = {L{8'h77}}; mt_comp = '1; mask = '1; in_cnt = 8'd128;
      out_ready = 1'b0; in_valid = 1'b1;
      @(negedge clk) lifm_comp = {L{8'h66}};
      @(negedge clk) in_valid = 1'b0;
      #1;
      vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_full got=%b/%b exp=0/1", in_ready, out_valid); end
      #2 reset_n = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_hs got=%b/%b exp=0/1", out_valid, in_ready); end
      vectors++; if (lifm_line !== '0 || mt_line !== '0 || out_cnt !== 8'd0) begin miscompares++; $display("FAIL mid_rst_data lifm_bits=%0d mt_bits=%0d cnt=%0d exp=0", $countones(lifm_line), $countones(mt_line), out_cnt); end
      @(negedge clk) reset_n = 1'b1; out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_stale got=%b/%b exp=0/1", out_valid, in_ready); end
      end
   endtask

   initial begin
      test_reset();
      test_all_ones();
      test_zero_mask();
      test_sparse();
      test_back_to_back();
      test_cnt_err();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/zvc_decompressor.md
Name: zvc_decompressor

Overview:
Zero-value decompressor. It is the inverse of the zero-value compressor's bubble-collapse step. The input is a compressed line (nonzero lowered-IFM words and mapping-table entries packed toward lane 0) plus the per-lane nonzero mask. The block scatters each packed entry back to its original lane and zero-fills the bubbles. It sits on the read-back path from the compressed line buffer to the PE array, as a 2-stage valid/ready pipeline.

Parameters:
WORD_WIDTH, 8, bits per lowered-IFM word
LINE_SIZE, 128, lanes per line (power of 2)
DIST_WIDTH, 7, bits per mapping-table distance field
MAX_LIFM_RSIZ, 4, distance fields per lane (mapping-table entry = DIST_WIDTH*MAX_LIFM_RSIZ bits)
CNT_WIDTH, 8, width of counts, equal to $clog2(LINE_SIZE)+1

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  compressed line valid
in_ready  output  1  block accepts line this cycle
lifm_comp  input  LINE_SIZE*WORD_WIDTH  packed words; lane k = bits [k*WORD_WIDTH +: WORD_WIDTH]
mt_comp  input  LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ  packed mapping-table entries, same lane order
mask  input  LINE_SIZE  bit i = 1 means original lane i was nonzero
in_cnt  input  CNT_WIDTH  number of packed entries claimed by the producer
out_valid  output  1  expanded line valid
out_ready  input  1  consumer accepts line
lifm_line  output  LINE_SIZE*WORD_WIDTH  expanded words
mt_line  output  LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ  expanded mapping table
out_cnt  output  CNT_WIDTH  popcount(mask) of the line on the output
cnt_err  output  1  in_cnt did not equal popcount(mask) for this line

Behaviour:
- Reset: out_valid, cnt_err, out_cnt, lifm_line and mt_line are all 0. Both stage valid bits are 0, so in_ready is 1 while reset_n is low and immediately after release.
- Handshake: a transfer occurs on a rising edge where valid and ready are both high. Data is captured only on a transfer.
  - While out_valid=1 and out_ready=0, all outputs must stay stable.
- Stage 1 (S1) registers, captured on an input transfer:
  - lifm_comp, mt_comp, mask.
  - Exclusive prefix sum psum[i] = popcount(mask[i-1:0]), with psum[0] = 0, each CNT_WIDTH bits wide.
  - total = popcount(mask).
  - err = (in_cnt != total).
- Stage 2 (S2) registers, which drive the outputs:
  - Lane i gets lifm_comp lane psum[i] and mt_comp lane psum[i] when mask[i]=1, otherwise all-zero.
  - out_cnt = total; cnt_err = err.
- Stall logic:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational; no combinational path from in_valid to in_ready).
  - out_valid = s2_valid.
- Latency: 2 cycles from input transfer to out_valid with no back-pressure. Throughput is 1 line/cycle. Lines emerge in order, with none dropped or duplicated.
- Full condition: both stages hold a line and out_ready=0 -> in_ready=0.
  - On the edge where out_ready returns high, S2 unloads, S1 moves to S2, and a new input is accepted in the same edge.
- Packed lanes at index >= total are ignored, whatever their value. Zero-filled lanes are exactly 0 even if mask=0 lanes would have nonzero data.
- mask all-zero: output is all-zero, out_cnt=0, and the line still flows through (it is not dropped).
- mask all-ones: output equals input, out_cnt=LINE_SIZE (128 fits in CNT_WIDTH).
- cnt_err is informational only. Expansion always uses mask, never in_cnt.
- Reset asserted mid-operation: all in-flight lines are discarded, outputs return to reset values asynchronously, and no partial line appears after release.

Test Plan:
- mask=all-ones, lifm_comp lane k = k, in_cnt=128 -> 2 cycles later lifm_line lane i = i, mt_line = mt_comp, out_cnt=128, cnt_err=0.
- mask=0, lifm_comp filled with 0xFF, in_cnt=0 -> lifm_line=0, mt_line=0, out_cnt=0, out_valid=1 for exactly one transfer.
- mask=0x5555...5, lifm_comp lane k = k+1 -> even lanes 2j = j+1, odd lanes 0, out_cnt=64. Also mask with only bit 127 set and lane 0 = 0xAB -> lane 127 = 0xAB, all other lanes 0.
- Back-pressure: issue lines A, B, C on consecutive cycles, out_ready=0 from cycle 2 -> in_ready drops with A in S2 and B in S1 and C held by the source. Hold 4 cycles with A stable on the outputs. Then out_ready=1 -> A, B, C delivered in order on consecutive cycles.
- mask popcount 10 with in_cnt=9 -> cnt_err=1 on that line only, data still expanded from the mask. The next line with matching in_cnt -> cnt_err=0.
- Assert reset_n low with both stages full -> out_valid=0 and outputs 0 immediately. After release, in_ready=1 and no stale line appears.
